button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
//
// PURPOSE
//  Front-end conditioning stage for the board push-buttons.
//  - Synchronises N raw, bouncing, asynchronous button inputs to clk and debounces each one independently.
//  - Outputs clean pressed levels, single-cycle press/release strobes, and a long-press flag.
//  - Feeds the LED counter/FSM logic, so that logic no longer needs its own edge detect or debounce timer.
//
// PARAMETERS
//  N_BTN            5          number of independent button channels
//  DEBOUNCE_CYCLES  1000000    consecutive stable cycles needed to accept a change (20 ms @ 50 MHz); must be >= 1
//  HOLD_CYCLES      50000000   cycles of continuous debounced press before btn_held asserts (1 s @ 50 MHz); must be >= 1
//  ACTIVE_LOW       1          1: raw input reads 0 when pressed (board default); 0: raw input reads 1 when pressed
//
// PORTS
//  clk          in   1      system clock, 50 MHz
//  rst          in   1      synchronous reset, active-high
//  button_raw   in   N_BTN  raw button pins, asynchronous, bouncing
//  btn_level    out  N_BTN  debounced level, 1 = pressed (always active-high)
//  btn_press    out  N_BTN  one-cycle strobe on an accepted released->pressed change
//  btn_release  out  N_BTN  one-cycle strobe on an accepted pressed->released change
//  btn_held     out  N_BTN  1 while pressed and pressed for >= HOLD_CYCLES
//
// BEHAVIOUR
//  Synchroniser
//  - Per channel: 2-flop synchroniser, then polarity normalise (pressed = 1).
//  - Synchroniser flops reset to the "released" raw level.
//  Per-channel FSM
//  - States: STABLE, SETTLE.
//  - STABLE, sync == btn_level: stay; cnt = 0.
//  - STABLE, sync != btn_level: go to SETTLE; cnt = 1.
//  - SETTLE, sync == btn_level (bounce back): go to STABLE; cnt = 0; outputs unchanged, no strobe.
//  - SETTLE, sync != btn_level, cnt < DEBOUNCE_CYCLES: cnt += 1.
//  - Acceptance: btn_level toggles on the edge where the mismatch has been seen on DEBOUNCE_CYCLES consecutive edges.
//    - On that edge the matching strobe (btn_press or btn_release) goes high for exactly one cycle.
//    - FSM returns to STABLE; cnt = 0.
//  Latency and widths
//  - Raw input changes before edge e and then stays stable: btn_level changes on edge e + DEBOUNCE_CYCLES + 1.
//  - Strobes are registered and coincide with the btn_level change.
//  - cnt width = $clog2(DEBOUNCE_CYCLES+1); cnt never exceeds DEBOUNCE_CYCLES.
//  Hold
//  - Per-channel hold counter clears while btn_level = 0 and counts while btn_level = 1.
//  - btn_held asserts on the edge the hold counter reaches HOLD_CYCLES; the counter then saturates (no wrap).
//  - btn_held deasserts on the same edge btn_level falls.
//  - btn_held never asserts in the cycle btn_press fires.
//  - Hold counter width = $clog2(HOLD_CYCLES+1).
//  Independence and strobes
//  - Channels are fully independent; simultaneous presses or releases on any subset give concurrent strobes.
//  - btn_press and btn_release are never both high on one channel in the same cycle.
//  Reset
//  - All outputs 0, all counters 0, all FSMs in STABLE.
//  - A reset asserted mid-SETTLE discards the pending change and emits no strobe.
//  - After reset, an input held pressed is accepted as a normal press: strobe at DEBOUNCE_CYCLES + 1 edges after rst deasserts.
//
// TESTING  (bench: DEBOUNCE_CYCLES=16, HOLD_CYCLES=64, N_BTN=5, ACTIVE_LOW=1)
//  1 Clean press: ch0 raw 1->0 before edge e.
//    -> btn_level[0] = 1 and btn_press[0] high only on edge e+17; no other channel moves.
//  2 Bounce reject: ch1 raw pulses low for 10 cycles, 3 times, with 5-cycle gaps.
//    -> no strobe, btn_level[1] stays 0.
//    Then hold low 16+ cycles -> exactly one btn_press[1].
//  3 Release: ch0 pressed and stable, raw 0->1.
//    -> btn_release[0] one cycle at +17 edges; btn_level[0] = 0 on the same edge.
//  4 Long press: ch2 held low 200 cycles.
//    -> btn_held[2] rises exactly 64 cycles after btn_press[2] and stays high.
//    Release -> btn_held[2] falls with btn_level[2].
//  5 Simultaneous: raw[4:0] all 1->0 on the same edge.
//    -> btn_press = 5'b11111 for one cycle on edge e+17.
//  6 Reset mid-operation: rst pulsed 8 cycles into a ch3 SETTLE.
//    -> all outputs 0, no strobe.
//    Raw still low -> btn_press[3] 17 edges after rst deasserts.

Source files
------------

// File: rtl/button_debouncer.sv
// Per-channel button conditioning: 2-flop synchroniser, polarity normalise,
// STABLE/SETTLE debounce FSM, press/release strobes and a long-press flag.
module button_debouncer #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_held
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  ACCEPT_AT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

    typedef enum logic {STABLE, SETTLE} state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            logic              sync1_reg, sync2_reg;
            logic              pressed;
            state_t            state_reg, state_next;
            logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_seen;
            logic              level_reg, level_next;
            logic              press_reg, press_next;
            logic              release_reg, release_next;
            logic [HOLD_W-1:0] hold_reg, hold_next;
            logic              held_out;

            assign pressed = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg   <= RELEASED_RAW;
                    sync2_reg   <= RELEASED_RAW;
                    state_reg   <= STABLE;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b0;
                    press_reg   <= 1'b0;
                    release_reg <= 1'b0;
                    hold_reg    <= '0;
                end else begin
                    sync1_reg   <= button_raw[gi];
                    sync2_reg   <= sync1_reg;
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    level_reg   <= level_next;
                    press_reg   <= press_next;
                    release_reg <= release_next;
                    hold_reg    <= hold_next;
                end
            end

            // cnt_seen = mismatching edges already observed before this one
            always_comb begin
                state_next   = state_reg;
                cnt_next     = '0;
                level_next   = level_reg;
                press_next   = 1'b0;
                release_next = 1'b0;
                cnt_seen     = (state_reg == SETTLE) ? cnt_reg : '0;
                if (pressed != level_reg) begin
                    if (cnt_seen == ACCEPT_AT) begin
                        state_next   = STABLE;
                        level_next   = pressed;
                        press_next   = pressed;
                        release_next = ~pressed;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = cnt_seen + CNT_W'(1);
                    end
                end else begin
                    state_next = STABLE;
                end

                if (!level_reg)
                    hold_next = '0;
                else if (hold_reg != HOLD_MAX)
                    hold_next = hold_reg + HOLD_W'(1);
                else
                    hold_next = hold_reg;
            end

            // Gating with level_reg drops btn_held on the same edge the level falls
            always_comb begin
                held_out = level_reg && (hold_reg == HOLD_MAX);
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign btn_held[gi]    = held_out;
        end
    endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE=16, HOLD=64, 5 channels, active-low).
module tb_button_debouncer;
    localparam int N  = 5;
    localparam int DB = 16;
    localparam int HC = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] button_raw = '1;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_held;

    int errors = 0;
    int checks = 0;

    button_debouncer #(.N_BTN(N), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .button_raw(button_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_held(btn_held)
    );

    always #5 clk = ~clk;

    // Event recorder: edge numbers of strobes and level/held transitions
    int           edge_no = 0;
    int           press_cnt [N];
    int           release_cnt [N];
    int           press_edge [N];
    int           release_edge [N];
    int           level_rise_edge [N];
    int           level_fall_edge [N];
    int           held_rise_edge [N];
    int           held_fall_edge [N];
    int           both_cnt = 0;
    int           press_cycles = 0;
    logic [N-1:0] last_press_vec = '0;
    int           last_press_vec_edge = -1;
    logic [N-1:0] prev_level = '0;
    logic [N-1:0] prev_held = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; release_cnt[i] = 0;
            press_edge[i] = -1; release_edge[i] = -1;
            level_rise_edge[i] = -1; level_fall_edge[i] = -1;
            held_rise_edge[i] = -1; held_fall_edge[i] = -1;
        end
    end

    always @(posedge clk) begin
        edge_no++;
        #1;
        if (btn_press != '0) begin
            press_cycles++;
            last_press_vec = btn_press;
            last_press_vec_edge = edge_no;
        end
        for (int i = 0; i < N; i++) begin
            if (btn_press[i]) begin press_cnt[i]++; press_edge[i] = edge_no; end
            if (btn_release[i]) begin release_cnt[i]++; release_edge[i] = edge_no; end
            if (btn_press[i] && btn_release[i]) both_cnt++;
            if (btn_level[i] && !prev_level[i]) level_rise_edge[i] = edge_no;
            if (!btn_level[i] && prev_level[i]) level_fall_edge[i] = edge_no;
            if (btn_held[i] && !prev_held[i]) held_rise_edge[i] = edge_no;
            if (!btn_held[i] && prev_held[i]) held_fall_edge[i] = edge_no;
        end
        prev_level = btn_level;
        prev_held  = btn_held;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_cycles(4);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_held} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got level=%b press=%b release=%b held=%b, need all 0",
                     btn_level, btn_press, btn_release, btn_held);
        end
        rst = 1'b0;
        wait_cycles(DB + 10);
        checks++;
        if (btn_level !== '0 || press_cnt[0] + press_cnt[4] !== 0) begin
            errors++;
            $display("FAIL reset_idle: got level=%b press0=%0d, need level 0 and no press", btn_level, press_cnt[0]);
        end
        $display("test_reset done");
    endtask

    task automatic test_clean_press;
        int e, p0;
        p0 = press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4];
        @(negedge clk);
        button_raw[0] = 1'b0;
        e = edge_no + 1;
        wait_cycles(DB + 10);
        checks++;
        if (press_edge[0] !== e + DB + 1 || press_cnt[0] !== 1) begin
            errors++;
            $display("FAIL clean_press_strobe: got edge=%0d count=%0d, need edge=%0d count=1", press_edge[0], press_cnt[0], e + DB + 1);
        end
        checks++;
        if (level_rise_edge[0] !== e + DB + 1 || btn_level !== 5'b00001) begin
            errors++;
            $display("FAIL clean_press_level: got rise=%0d level=%b, need rise=%0d level=00001", level_rise_edge[0], btn_level, e + DB + 1);
        end
        checks++;
        if (press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4] !== p0) begin
            errors++;
            $display("FAIL clean_press_others: other channels pressed");
        end
        $display("test_clean_press: press edge %0d", press_edge[0]);
    endtask

    task automatic test_bounce;
        int p0;
        p0 = press_cnt[1];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            button_raw[1] = 1'b0;
            wait_cycles(10);
            button_raw[1] = 1'b1;
            wait_cycles(5);
        end
        wait_cycles(DB + 5);
        checks++;
        if (press_cnt[1] !== p0 || btn_level[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_reject: got presses=%0d level=%b, need presses=%0d level=0", press_cnt[1], btn_level[1], p0);
        end
        button_raw[1] = 1'b0;
        wait_cycles(DB + 10);
        checks++;
        if (press_cnt[1] !== p0 + 1 || btn_level[1] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_accept: got presses=%0d level=%b, need presses=%0d level=1", press_cnt[1], btn_level[1], p0 + 1);
        end
        $display("test_bounce: presses on ch1 = %0d", press_cnt[1] - p0);
    endtask

    task automatic test_release;
        int e, r0;
        r0 = release_cnt[0];
        @(negedge clk);
        button_raw[0] = 1'b1;
        e = edge_no + 1;
        wait_cycles(DB + 10);
        checks++;
        if (release_edge[0] !== e + DB + 1 || release_cnt[0] !== r0 + 1) begin
            errors++;
            $display("FAIL release_strobe: got edge=%0d count=%0d, need edge=%0d count=%0d", release_edge[0], release_cnt[0], e + DB + 1, r0 + 1);
        end
        checks++;
        if (level_fall_edge[0] !== e + DB + 1 || btn_level[0] !== 1'b0) begin
            errors++;
            $display("FAIL release_level: got fall=%0d level=%b, need fall=%0d level=0", level_fall_edge[0], btn_level[0], e + DB + 1);
        end
        $display("test_release: release edge %0d", release_edge[0]);
    endtask

    task automatic test_long_press;
        @(negedge clk);
        button_raw[2] = 1'b0;
        wait_cycles(200);
        checks++;
        if (press_edge[2] < 0 || held_rise_edge[2] !== press_edge[2] + HC) begin
            errors++;
            $display("FAIL long_press_rise: got held rise=%0d, need %0d", held_rise_edge[2], press_edge[2] + HC);
        end
        checks++;
        if (btn_held[2] !== 1'b1) begin
            errors++;
            $display("FAIL long_press_stays: got held=%b, need 1", btn_held[2]);
        end
        button_raw[2] = 1'b1;
        wait_cycles(DB + 10);
        checks++;
        if (btn_held[2] !== 1'b0 || held_fall_edge[2] < 0 || held_fall_edge[2] !== level_fall_edge[2]) begin
            errors++;
            $display("FAIL long_press_fall: got held=%b fall=%0d, need held=0 fall=%0d", btn_held[2], held_fall_edge[2], level_fall_edge[2]);
        end
        $display("test_long_press: held rose at %0d, fell at %0d", held_rise_edge[2], held_fall_edge[2]);
    endtask

    task automatic test_simultaneous;
        int e, pc;
        button_raw = '1;
        wait_cycles(DB + 10);
        pc = press_cycles;
        @(negedge clk);
        button_raw = '0;
        e = edge_no + 1;
        wait_cycles(DB + 10);
        checks++;
        if (last_press_vec !== 5'b11111 || last_press_vec_edge !== e + DB + 1 || press_cycles !== pc + 1) begin
            errors++;
            $display("FAIL simultaneous: got vec=%b edge=%0d cycles=%0d, need vec=11111 edge=%0d cycles=1",
                     last_press_vec, last_press_vec_edge, press_cycles - pc, e + DB + 1);
        end
        button_raw = '1;
        wait_cycles(DB + 10);
        $display("test_simultaneous: press vector %b at edge %0d", last_press_vec, last_press_vec_edge);
    endtask

    task automatic test_reset_mid;
        int e, p0;
        p0 = press_cnt[3];
        @(negedge clk);
        button_raw[3] = 1'b0;
        wait_cycles(10);
        rst = 1'b1;
        wait_cycles(3);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_held} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got level=%b press=%b, need all 0", btn_level, btn_press);
        end
        rst = 1'b0;
        e = edge_no + 1;
        wait_cycles(DB + 10);
        checks++;
        if (press_cnt[3] !== p0 + 1 || press_edge[3] !== e + DB + 1) begin
            errors++;
            $display("FAIL reset_mid_press: got count=%0d edge=%0d, need count=%0d edge=%0d", press_cnt[3], press_edge[3], p0 + 1, e + DB + 1);
        end
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL press_release_exclusive: got %0d overlapping cycles, need 0", both_cnt);
        end
        $display("test_reset_mid: ch3 press edge %0d", press_edge[3]);
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_release;
        test_long_press;
        test_simultaneous;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
